// File: rtl/sa_axis_frame_tx.sv
// ---------------------------------------------------------------------------
// sa_axis_frame_tx
//
// AXI4-Stream frame transmitter that feeds the systolic array's input
// stream. A frame is MAT_BEATS matrix beats followed by a run of vector
// beats, with tlast on the final vector beat. The host fills a local beat
// buffer through a simple write port; a start pulse then streams one frame
// out of that buffer, with full tready backpressure.
//
// Optional build macro:
//   SA_TX_WR_LOCK_EN  - when defined, buffer writes are refused while a frame
//                       is in flight and raise the sticky wr_err flag.
//                       When undefined, writes during a frame land at once
//                       and wr_err is tied low.
//
// Ports:
//   m00_axis_aclk    in   clock
//   m00_axis_areset  in   asynchronous reset, active-high
//   wr_en            in   buffer write strobe
//   wr_addr          in   buffer beat index (AW bits)
//   wr_data          in   beat data, lane 0 in the LSBs
//   cfg_vec_beats    in   vector beats for the next frame (0 = maximum)
//   start            in   single-cycle request to send one frame
//   busy             out  frame in progress
//   done             out  single-cycle pulse after the final beat is taken
//   wr_err           out  sticky flag: a write was refused
//   m00_axis_tdata   out  stream data
//   m00_axis_tvalid  out  stream valid
//   m00_axis_tready  in   stream ready
//   m00_axis_tlast   out  final beat of frame
// ---------------------------------------------------------------------------
module sa_axis_frame_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 4,
  parameter int MAT_BEATS  = 3,
  parameter int VEC_BEATS  = 12,
  localparam int DEPTH     = MAT_BEATS + VEC_BEATS,
  localparam int AW        = $clog2(DEPTH),
  localparam int TW        = LANES * DATA_WIDTH
) (
  input  logic          m00_axis_aclk,
  input  logic          m00_axis_areset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [TW-1:0] wr_data,
  input  logic [AW:0]   cfg_vec_beats,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          wr_err,
  output logic [TW-1:0] m00_axis_tdata,
  output logic          m00_axis_tvalid,
  input  logic          m00_axis_tready,
  output logic          m00_axis_tlast
);

  localparam logic [AW:0] VEC_MAX = (AW+1)'(VEC_BEATS);
  localparam logic [AW:0] MAT_LEN = (AW+1)'(MAT_BEATS);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] beat_buf [DEPTH];
  logic [AW-1:0] idx, idx_nxt;
  logic [AW-1:0] last_idx, last_idx_nxt;
  logic [AW-1:0] idx_inc;
  logic [TW-1:0] tdata_nxt;
  logic          tlast_nxt;
  logic          done_nxt;
  logic          addr_ok;
  logic          wr_ok;
  logic          handshake;
  logic [AW:0]   vec_len;
  logic [AW:0]   frame_last_w;
  logic [AW-1:0] cfg_last;
  logic [TW-1:0] rd_first;
  logic [TW-1:0] rd_next;

  // valid and busy both mean "a frame is being presented", so they come
  // straight from the state register and fall with the async reset.
  assign busy            = (state == SEND);
  assign m00_axis_tvalid = (state == SEND);
  assign handshake       = m00_axis_tvalid && m00_axis_tready;
  assign idx_inc         = idx + AW'(1);
  assign addr_ok         = ({1'b0, wr_addr} < DEPTH_W);

`ifdef SA_TX_WR_LOCK_EN
  // Buffer is frozen for the whole frame; any write attempt during a frame
  // is refused and remembered until reset.
  assign wr_ok = wr_en && addr_ok && (state == IDLE);

  always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
    if (m00_axis_areset) begin
      wr_err <= 1'b0;
    end else if (wr_en && (state == SEND)) begin
      wr_err <= 1'b1;
    end
  end
`else
  // Writes always land; the frame picks up new data for beats it has not
  // yet presented.
  assign wr_ok  = wr_en && addr_ok;
  assign wr_err = 1'b0;
`endif

  // Beat buffer: plain storage, deliberately not reset.
  always_ff @(posedge m00_axis_aclk) begin
    if (wr_ok) begin
      beat_buf[wr_addr] <= wr_data;
    end
  end

  // Buffer reads for the beat about to be loaded into the output register.
  // A write to that same address in the same cycle is forwarded so a beat
  // that is not yet on the bus always reflects the newest data, while the
  // beat currently presented stays untouched in the output register.
  always_comb begin
    rd_first = beat_buf[0];
    rd_next  = beat_buf[idx_inc];
    if (wr_ok && (wr_addr == '0)) begin
      rd_first = wr_data;
    end
    if (wr_ok && (wr_addr == idx_inc)) begin
      rd_next = wr_data;
    end
  end

  // Vector length for the next frame: zero or anything above the buffer's
  // vector region means "use the full vector region". The result is the
  // index of the final beat, which always fits in AW bits.
  always_comb begin
    vec_len = cfg_vec_beats;
    if ((cfg_vec_beats == '0) || (cfg_vec_beats > VEC_MAX)) begin
      vec_len = VEC_MAX;
    end
    frame_last_w = MAT_LEN + vec_len - (AW+1)'(1);
    cfg_last     = frame_last_w[AW-1:0];
  end

  // Next-state and output logic. The output register is loaded with the
  // next beat on the same edge that accepts the current one, so beats flow
  // back-to-back; on a stall nothing is loaded and tdata/tlast hold.
  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    last_idx_nxt = last_idx;
    tdata_nxt    = m00_axis_tdata;
    tlast_nxt    = m00_axis_tlast;
    done_nxt     = 1'b0;
    case (state)
      IDLE: begin
        tdata_nxt = '0;
        tlast_nxt = 1'b0;
        if (start) begin
          state_nxt    = SEND;
          idx_nxt      = '0;
          last_idx_nxt = cfg_last;
          tdata_nxt    = rd_first;
          tlast_nxt    = (cfg_last == '0);
        end
      end
      SEND: begin
        if (handshake) begin
          if (idx == last_idx) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
            tdata_nxt = '0;
            tlast_nxt = 1'b0;
            done_nxt  = 1'b1;
          end else begin
            idx_nxt   = idx_inc;
            tdata_nxt = rd_next;
            tlast_nxt = (idx_inc == last_idx);
          end
        end
      end
    endcase
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
    if (m00_axis_areset) begin
      state          <= IDLE;
      idx            <= '0;
      last_idx       <= '0;
      m00_axis_tdata <= '0;
      m00_axis_tlast <= 1'b0;
      done           <= 1'b0;
    end else begin
      state          <= state_nxt;
      idx            <= idx_nxt;
      last_idx       <= last_idx_nxt;
      m00_axis_tdata <= tdata_nxt;
      m00_axis_tlast <= tlast_nxt;
      done           <= done_nxt;
    end
  end

endmodule

// File: tb/tb_sa_axis_frame_tx.sv
// ---------------------------------------------------------------------------
// tb_sa_axis_frame_tx
//
// Directed self-checking bench for sa_axis_frame_tx with the default
// parameters (16-bit lanes, 4 lanes, 3 matrix beats, 12 vector beats).
// Inputs change 1 time unit after the rising edge; outputs are read at the
// same point, so what is read is what the DUT will see on the next edge.
// ---------------------------------------------------------------------------
module tb_sa_axis_frame_tx;

  localparam int TW = 64;
  localparam logic [TW-1:0] DEAD = 64'hdead_beef_0000_1111;

  logic          m00_axis_aclk;
  logic          m00_axis_areset;
  logic          wr_en;
  logic [3:0]    wr_addr;
  logic [TW-1:0] wr_data;
  logic [4:0]    cfg_vec_beats;
  logic          start;
  logic          busy;
  logic          done;
  logic          wr_err;
  logic [TW-1:0] m00_axis_tdata;
  logic          m00_axis_tvalid;
  logic          m00_axis_tready;
  logic          m00_axis_tlast;

  int tests_run = 0;
  int failures  = 0;

  // Results of the most recent collect_frame call.
  logic [TW-1:0] got_d [32];
  logic          got_l [32];
  int            n_beats;
  int            cyc_used;
  int            stall_viol;
  int            drop_viol;
  bit            timed_out;
  logic          first_valid;
  logic          done_after;
  logic [7:0]    lfsr;

  sa_axis_frame_tx dut (
    .m00_axis_aclk   (m00_axis_aclk),
    .m00_axis_areset (m00_axis_areset),
    .wr_en           (wr_en),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .cfg_vec_beats   (cfg_vec_beats),
    .start           (start),
    .busy            (busy),
    .done            (done),
    .wr_err          (wr_err),
    .m00_axis_tdata  (m00_axis_tdata),
    .m00_axis_tvalid (m00_axis_tvalid),
    .m00_axis_tready (m00_axis_tready),
    .m00_axis_tlast  (m00_axis_tlast)
  );

  initial m00_axis_aclk = 1'b0;
  always #5 m00_axis_aclk = ~m00_axis_aclk;

  // Four consecutive lane values 4j..4j+3, lane 0 in the LSBs.
  function automatic logic [TW-1:0] pattern(input int j);
    logic [15:0] b;
    b = 16'(4 * j);
    return {b + 16'd3, b + 16'd2, b + 16'd1, b};
  endfunction

  // Expected buffer contents: matrix beats use pattern(k), vector beat i
  // uses pattern(i).
  function automatic logic [TW-1:0] exp_beat(input int k);
    return (k < 3) ? pattern(k) : pattern(k - 3);
  endfunction

  task automatic tick();
    @(posedge m00_axis_aclk);
    #1;
  endtask

  task automatic write_beat(input int addr, input logic [TW-1:0] data);
    wr_en   = 1'b1;
    wr_addr = 4'(addr);
    wr_data = data;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic load_buffer();
    for (int a = 0; a < 15; a++) begin
      write_beat(a, exp_beat(a));
    end
    write_beat(15, 64'hffff_ffff_ffff_ffff);
  endtask

  task automatic start_frame(input int cfg);
    cfg_vec_beats = 5'(cfg);
    start         = 1'b1;
    tick();
    start         = 1'b0;
  endtask

  // Runs the stream side until tlast is accepted (or a budget expires),
  // recording every accepted beat and any AXIS rule breaks. Optional side
  // actions: pulse start when a given beat is on the bus or in the final
  // handshake cycle, and issue one write to address 10 at a given beat.
  task automatic collect_frame(input int rmode, input int start_at,
                               input bit start_final, input int wr_at);
    bit            fin;
    bit            stalled;
    bit            wrote;
    logic [TW-1:0] hold_d;
    logic          hold_l;
    n_beats     = 0;
    cyc_used    = 0;
    stall_viol  = 0;
    drop_viol   = 0;
    timed_out   = 1'b0;
    first_valid = m00_axis_tvalid;
    fin         = 1'b0;
    stalled     = 1'b0;
    wrote       = 1'b0;
    hold_d      = '0;
    hold_l      = 1'b0;
    while (!fin && cyc_used < 400) begin
      if (!m00_axis_tvalid) drop_viol++;
      if (stalled && (m00_axis_tdata !== hold_d || m00_axis_tlast !== hold_l))
        stall_viol++;
      if (rmode != 0) begin
        lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        m00_axis_tready = lfsr[0];
      end else begin
        m00_axis_tready = 1'b1;
      end
      start = (start_at >= 0 && n_beats == start_at) ||
              (start_final && m00_axis_tlast && m00_axis_tready);
      if (!wrote && wr_at >= 0 && n_beats == wr_at) begin
        wr_en   = 1'b1;
        wr_addr = 4'd10;
        wr_data = DEAD;
        wrote   = 1'b1;
      end
      if (m00_axis_tvalid && m00_axis_tready) begin
        got_d[n_beats] = m00_axis_tdata;
        got_l[n_beats] = m00_axis_tlast;
        n_beats++;
        if (m00_axis_tlast || n_beats >= 31) fin = 1'b1;
        stalled = 1'b0;
      end else begin
        stalled = m00_axis_tvalid;
        hold_d  = m00_axis_tdata;
        hold_l  = m00_axis_tlast;
      end
      tick();
      start = 1'b0;
      wr_en = 1'b0;
      cyc_used++;
    end
    m00_axis_tready = 1'b0;
    timed_out  = !fin;
    done_after = done;
  endtask

  task automatic test_reset();
    m00_axis_areset = 1'b1;
    tick();
    tick();
    tests_run++;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got %b expected 0", busy); end
    tests_run++;
    if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got %b expected 0", done); end
    tests_run++;
    if (wr_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_wr_err got %b expected 0", wr_err); end
    tests_run++;
    if (m00_axis_tvalid !== 1'b0 || m00_axis_tlast !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_valid_last got %b%b expected 00", m00_axis_tvalid, m00_axis_tlast);
    end
    tests_run++;
    if (m00_axis_tdata !== '0) begin failures++; $display("[TB] FAIL reset_tdata got %h expected 0", m00_axis_tdata); end
    m00_axis_areset = 1'b0;
    tick();
  endtask

  task automatic test_full_frame();
    load_buffer();
    tests_run++;
    if (wr_err !== 1'b0) begin failures++; $display("[TB] FAIL load_wr_err got %b expected 0", wr_err); end
    start_frame(0);
    collect_frame(0, -1, 1'b0, -1);
    tests_run++;
    if (first_valid !== 1'b1) begin failures++; $display("[TB] FAIL full_first_valid got %b expected 1", first_valid); end
    tests_run++;
    if (n_beats != 15 || timed_out) begin failures++; $display("[TB] FAIL full_beats got %0d expected 15", n_beats); end
    tests_run++;
    if (cyc_used != 15) begin failures++; $display("[TB] FAIL full_cycles got %0d expected 15", cyc_used); end
    for (int i = 0; i < n_beats && i < 15; i++) begin
      tests_run++;
      if (got_d[i] !== exp_beat(i) || got_l[i] !== (i == 14)) begin
        failures++;
        $display("[TB] FAIL full_beat%0d got %h/%b expected %h/%b", i, got_d[i], got_l[i], exp_beat(i), (i == 14));
      end
    end
    tests_run++;
    if (got_d[14] !== 64'h002f_002e_002d_002c) begin
      failures++;
      $display("[TB] FAIL full_beat14_const got %h expected 002f002e002d002c", got_d[14]);
    end
    tests_run++;
    if (done_after !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL full_done got done=%b busy=%b expected done=1 busy=0", done_after, busy);
    end
    tick();
    tests_run++;
    if (done !== 1'b0) begin failures++; $display("[TB] FAIL full_done_pulse got %b expected 0", done); end
  endtask

  task automatic test_backpressure();
    start_frame(0);
    collect_frame(1, -1, 1'b0, -1);
    tests_run++;
    if (n_beats != 15 || timed_out) begin failures++; $display("[TB] FAIL bp_beats got %0d expected 15", n_beats); end
    tests_run++;
    if (cyc_used <= 15) begin failures++; $display("[TB] FAIL bp_no_stalls got %0d cycles expected >15", cyc_used); end
    tests_run++;
    if (stall_viol != 0 || drop_viol != 0) begin
      failures++;
      $display("[TB] FAIL bp_stable got %0d/%0d rule breaks expected 0/0", stall_viol, drop_viol);
    end
    for (int i = 0; i < n_beats && i < 15; i++) begin
      tests_run++;
      if (got_d[i] !== exp_beat(i) || got_l[i] !== (i == 14)) begin
        failures++;
        $display("[TB] FAIL bp_beat%0d got %h/%b expected %h/%b", i, got_d[i], got_l[i], exp_beat(i), (i == 14));
      end
    end
    tick();
  endtask

  task automatic test_vec_len();
    start_frame(2);
    collect_frame(0, -1, 1'b0, -1);
    tests_run++;
    if (n_beats != 5 || timed_out) begin failures++; $display("[TB] FAIL len2_beats got %0d expected 5", n_beats); end
    tests_run++;
    if (got_d[4] !== 64'h0007_0006_0005_0004 || got_l[4] !== 1'b1 || got_l[3] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL len2_last got %h/%b expected 0007000600050004/1", got_d[4], got_l[4]);
    end
    tick();
    start_frame(20);
    collect_frame(0, -1, 1'b0, -1);
    tests_run++;
    if (n_beats != 15 || timed_out) begin failures++; $display("[TB] FAIL len20_beats got %0d expected 15", n_beats); end
    tests_run++;
    if (got_d[14] !== exp_beat(14)) begin failures++; $display("[TB] FAIL len20_last got %h expected %h", got_d[14], exp_beat(14)); end
    tick();
  endtask

  task automatic test_start_ignored();
    start_frame(0);
    collect_frame(0, 5, 1'b1, -1);
    tests_run++;
    if (n_beats != 15 || cyc_used != 15) begin
      failures++;
      $display("[TB] FAIL ign_beats got %0d in %0d cycles expected 15 in 15", n_beats, cyc_used);
    end
    tests_run++;
    if (m00_axis_tvalid !== 1'b0 || done_after !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ign_done got valid=%b done=%b expected 0/1", m00_axis_tvalid, done_after);
    end
    tick();
    tests_run++;
    if (m00_axis_tvalid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ign_no_requeue got valid=%b busy=%b expected 0/0", m00_axis_tvalid, busy);
    end
    // Back-to-back: start rides on the done cycle of the previous frame.
    start_frame(0);
    collect_frame(0, -1, 1'b0, -1);
    start = 1'b1;
    tick();
    start = 1'b0;
    tests_run++;
    if (m00_axis_tvalid !== 1'b1 || m00_axis_tdata !== exp_beat(0)) begin
      failures++;
      $display("[TB] FAIL b2b_first got valid=%b data=%h expected 1/%h", m00_axis_tvalid, m00_axis_tdata, exp_beat(0));
    end
    collect_frame(0, -1, 1'b0, -1);
    tests_run++;
    if (n_beats != 15 || timed_out) begin failures++; $display("[TB] FAIL b2b_beats got %0d expected 15", n_beats); end
    tick();
  endtask

  task automatic test_reset_mid_frame();
    int k;
    int guard;
    start_frame(0);
    m00_axis_tready = 1'b1;
    k = 0;
    guard = 0;
    while (k < 7 && guard < 50) begin
      if (m00_axis_tvalid && m00_axis_tready) k++;
      tick();
      guard++;
    end
    m00_axis_tready = 1'b0;
    tests_run++;
    if (m00_axis_tdata !== exp_beat(7) || k != 7) begin
      failures++;
      $display("[TB] FAIL rst_beat7 got %h expected %h", m00_axis_tdata, exp_beat(7));
    end
    #2;
    m00_axis_areset = 1'b1;
    #1;
    tests_run++;
    if (m00_axis_tvalid !== 1'b0 || busy !== 1'b0 || m00_axis_tlast !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rst_async got valid=%b busy=%b last=%b expected 0/0/0", m00_axis_tvalid, busy, m00_axis_tlast);
    end
    tests_run++;
    if (m00_axis_tdata !== '0) begin failures++; $display("[TB] FAIL rst_tdata got %h expected 0", m00_axis_tdata); end
    tick();
    m00_axis_areset = 1'b0;
    tick();
    start_frame(0);
    collect_frame(0, -1, 1'b0, -1);
    tests_run++;
    if (n_beats != 15 || timed_out) begin failures++; $display("[TB] FAIL rst_restart_beats got %0d expected 15", n_beats); end
    tests_run++;
    if (got_d[0] !== exp_beat(0) || got_d[14] !== exp_beat(14)) begin
      failures++;
      $display("[TB] FAIL rst_restart_data got %h..%h expected %h..%h", got_d[0], got_d[14], exp_beat(0), exp_beat(14));
    end
    tick();
  endtask

  task automatic test_write_busy();
    logic [TW-1:0] exp10;
    logic          exp_err;
`ifdef SA_TX_WR_LOCK_EN
    exp10   = exp_beat(10);
    exp_err = 1'b1;
`else
    exp10   = DEAD;
    exp_err = 1'b0;
`endif
    start_frame(0);
    collect_frame(0, -1, 1'b0, 9);
    tests_run++;
    if (got_d[10] !== exp10) begin failures++; $display("[TB] FAIL wr_beat10 got %h expected %h", got_d[10], exp10); end
    tests_run++;
    if (got_d[9] !== exp_beat(9) || got_d[11] !== exp_beat(11)) begin
      failures++;
      $display("[TB] FAIL wr_neighbours got %h/%h expected %h/%h", got_d[9], got_d[11], exp_beat(9), exp_beat(11));
    end
    tests_run++;
    if (wr_err !== exp_err) begin failures++; $display("[TB] FAIL wr_err got %b expected %b", wr_err, exp_err); end
    write_beat(10, exp_beat(10));
    tick();
    tests_run++;
    if (wr_err !== exp_err) begin failures++; $display("[TB] FAIL wr_err_sticky got %b expected %b", wr_err, exp_err); end
    m00_axis_areset = 1'b1;
    tick();
    m00_axis_areset = 1'b0;
    tick();
    tests_run++;
    if (wr_err !== 1'b0) begin failures++; $display("[TB] FAIL wr_err_cleared got %b expected 0", wr_err); end
    start_frame(0);
    collect_frame(0, -1, 1'b0, -1);
    tests_run++;
    if (got_d[10] !== exp_beat(10)) begin failures++; $display("[TB] FAIL wr_restored got %h expected %h", got_d[10], exp_beat(10)); end
  endtask

  initial begin
    m00_axis_areset = 1'b1;
    wr_en           = 1'b0;
    wr_addr         = '0;
    wr_data         = '0;
    cfg_vec_beats   = '0;
    start           = 1'b0;
    m00_axis_tready = 1'b0;
    lfsr            = 8'ha5;
    #1;
    test_reset();
    test_full_frame();
    test_backpressure();
    test_vec_len();
    test_start_ignored();
    test_reset_mid_frame();
    test_write_busy();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
